// File: rtl/cond_unit.sv
// ============================================================================
// Module   : cond_unit
// Brief    : Execute-stage ARM condition evaluation, flag register, write
//            gating and executed/annulled instruction event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             valid_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_write_e,
    input  logic [3:0]       alu_flags,
    input  logic             pc_src_e,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             branch_e,
    output logic [3:0]       flags,
    output logic             cond_ex_e,
    output logic             pc_src_g,
    output logic             reg_write_g,
    output logic             mem_write_g,
    output logic             branch_taken_e,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] annul_count
);

    localparam logic [3:0] c_EQ = 4'b0000;
    localparam logic [3:0] c_NE = 4'b0001;
    localparam logic [3:0] c_CS = 4'b0010;
    localparam logic [3:0] c_CC = 4'b0011;
    localparam logic [3:0] c_MI = 4'b0100;
    localparam logic [3:0] c_PL = 4'b0101;
    localparam logic [3:0] c_VS = 4'b0110;
    localparam logic [3:0] c_VC = 4'b0111;
    localparam logic [3:0] c_HI = 4'b1000;
    localparam logic [3:0] c_LS = 4'b1001;
    localparam logic [3:0] c_GE = 4'b1010;
    localparam logic [3:0] c_LT = 4'b1011;
    localparam logic [3:0] c_GT = 4'b1100;
    localparam logic [3:0] c_LE = 4'b1101;
    localparam logic [3:0] c_AL = 4'b1110;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_annul_cnt;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_pass;
    logic w_cond_ex;
    logic w_advance;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluated on the registered flags only, so a flag-setting conditional
    // instruction is judged against the state before its own write.
    always_comb begin
        w_pass = 1'b0;
        case (cond_e)
            c_EQ:    w_pass = w_z;
            c_NE:    w_pass = ~w_z;
            c_CS:    w_pass = w_c;
            c_CC:    w_pass = ~w_c;
            c_MI:    w_pass = w_n;
            c_PL:    w_pass = ~w_n;
            c_VS:    w_pass = w_v;
            c_VC:    w_pass = ~w_v;
            c_HI:    w_pass = w_c & ~w_z;
            c_LS:    w_pass = ~w_c | w_z;
            c_GE:    w_pass = (w_n == w_v);
            c_LT:    w_pass = (w_n != w_v);
            c_GT:    w_pass = ~w_z & (w_n == w_v);
            c_LE:    w_pass = w_z | (w_n != w_v);
            c_AL:    w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    assign w_cond_ex = w_pass & valid_e;
    assign w_advance = ~stall_e & valid_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags     <= 4'b0000;
            r_exec_cnt  <= {CNT_W{1'b0}};
            r_annul_cnt <= {CNT_W{1'b0}};
        end else if (w_advance) begin
            if (w_cond_ex) begin
                if (flag_write_e[1]) begin
                    r_flags[3:2] <= alu_flags[3:2];
                end
                if (flag_write_e[0]) begin
                    r_flags[1:0] <= alu_flags[1:0];
                end
                r_exec_cnt <= r_exec_cnt + c_CNT_ONE;
            end else begin
                r_annul_cnt <= r_annul_cnt + c_CNT_ONE;
            end
        end
    end

    // Gated controls ignore stall; downstream registers honour it themselves.
    assign flags          = r_flags;
    assign cond_ex_e      = w_cond_ex;
    assign pc_src_g       = pc_src_e & w_cond_ex;
    assign reg_write_g    = reg_write_e & w_cond_ex;
    assign mem_write_g    = mem_write_e & w_cond_ex;
    assign branch_taken_e = branch_e & w_cond_ex;
    assign exec_count     = r_exec_cnt;
    assign annul_count    = r_annul_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cond_unit.sv
// ============================================================================
// Module   : tb_cond_unit
// Brief    : Self-checking bench for cond_unit: directed scenarios followed by
//            randomized traffic compared against a behavioural flag model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_unit;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic             stall_e;
    logic             valid_e;
    logic [3:0]       cond_e;
    logic [1:0]       flag_write_e;
    logic [3:0]       alu_flags;
    logic             pc_src_e;
    logic             reg_write_e;
    logic             mem_write_e;
    logic             branch_e;
    logic [3:0]       flags;
    logic             cond_ex_e;
    logic             pc_src_g;
    logic             reg_write_g;
    logic             mem_write_g;
    logic             branch_taken_e;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] annul_count;

    int n_checks;
    int n_fail;

    // Behavioural model state
    logic [3:0]       m_flags;
    logic [CNT_W-1:0] m_exec;
    logic [CNT_W-1:0] m_annul;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_e        (stall_e),
        .valid_e        (valid_e),
        .cond_e         (cond_e),
        .flag_write_e   (flag_write_e),
        .alu_flags      (alu_flags),
        .pc_src_e       (pc_src_e),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .branch_e       (branch_e),
        .flags          (flags),
        .cond_ex_e      (cond_ex_e),
        .pc_src_g       (pc_src_g),
        .reg_write_g    (reg_write_g),
        .mem_write_g    (mem_write_g),
        .branch_taken_e (branch_taken_e),
        .exec_count     (exec_count),
        .annul_count    (annul_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Condition groups in pairs: odd codes are the complement of the even one.
    function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hE) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    task automatic check_comb(input string tag);
        bit ex;
        ex = valid_e && m_pass(cond_e, m_flags);
        chk({tag, ".cond_ex"},   cond_ex_e,      ex);
        chk({tag, ".pc_src"},    pc_src_g,       pc_src_e && ex);
        chk({tag, ".reg_write"}, reg_write_g,    reg_write_e && ex);
        chk({tag, ".mem_write"}, mem_write_g,    mem_write_e && ex);
        chk({tag, ".branch"},    branch_taken_e, branch_e && ex);
    endtask

    task automatic tick(input string tag);
        bit ex;
        ex = valid_e && m_pass(cond_e, m_flags);
        @(posedge clk);
        #1;
        if (reset) begin
            m_flags = 4'b0000;
            m_exec  = '0;
            m_annul = '0;
        end else if (!stall_e && valid_e) begin
            if (ex) begin
                if (flag_write_e[1]) m_flags[3:2] = alu_flags[3:2];
                if (flag_write_e[0]) m_flags[1:0] = alu_flags[1:0];
                m_exec = m_exec + 1'b1;
            end else begin
                m_annul = m_annul + 1'b1;
            end
        end
        chk({tag, ".flags"}, flags,       m_flags);
        chk({tag, ".exec"},  exec_count,  m_exec);
        chk({tag, ".annul"}, annul_count, m_annul);
    endtask

    task automatic drive(input logic rst, input logic st, input logic v,
                         input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input logic pc, input logic rw, input logic mw, input logic br);
        reset = rst; stall_e = st; valid_e = v; cond_e = c; flag_write_e = fw;
        alu_flags = af; pc_src_e = pc; reg_write_e = rw; mem_write_e = mw; branch_e = br;
    endtask

    task automatic step(input string tag, input logic rst, input logic st, input logic v,
                        input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                        input logic pc, input logic rw, input logic mw, input logic br);
        drive(rst, st, v, c, fw, af, pc, rw, mw, br);
        #1;
        check_comb(tag);
        tick(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_flags  = 4'b0000;
        m_exec   = '0;
        m_annul  = '0;
        drive(1'b1, 1'b0, 1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset state, EQ with Z=0 during reset
        chk("rst.flags", flags, 4'b0000);
        chk("rst.cond_ex", cond_ex_e, 1'b0);
        chk("rst.exec", exec_count, 0);
        chk("rst.annul", annul_count, 0);
        step("rst_eq", 1'b1, 1'b0, 1'b1, 4'h0, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_al.cond_ex", cond_ex_e, 1'b1);
        tick("rst_al");

        // AL sets Z, then EQ branch sees it back-to-back
        step("al_setz", 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("al_setz.flags_abs", flags, 4'b0100);
        drive(1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("eq_br.taken_abs", branch_taken_e, 1'b1);
        check_comb("eq_br");
        tick("eq_br");
        chk("eq_br.exec_abs", exec_count, 2);

        // Clear flags, write N,Z half only, GE fails, LT passes
        step("clr", 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nz_only", 1'b0, 1'b0, 1'b1, 4'hE, 2'b10, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nz_only.flags_abs", flags, 4'b1000);
        drive(1'b0, 1'b0, 1'b1, 4'hA, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("ge.cond_ex_abs", cond_ex_e, 1'b0);
        tick("ge");
        drive(1'b0, 1'b0, 1'b1, 4'hB, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lt.reg_write_abs", reg_write_g, 1'b1);
        tick("lt");

        // Annulled CMPNE leaves flags alone
        step("setz2", 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4'h1, 2'b11, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("ne.mem_write_abs", mem_write_g, 1'b0);
        tick("ne");
        chk("ne.flags_abs", flags, 4'b0100);

        // Stalled AL flag-setter held 3 cycles then released
        for (int i = 0; i < 3; i++)
            step("stall", 1'b0, 1'b1, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall.flags_abs", flags, 4'b0100);
        step("release", 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("release.flags_abs", flags, 4'b1111);

        // Unconditional space annulled; bubble changes nothing
        step("nv", 1'b0, 1'b0, 1'b1, 4'hF, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1);
        step("bubble", 1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1);

        // Mid-stream reset wins over stall and a valid flag-setter
        step("mid_rst", 1'b1, 1'b1, 1'b1, 4'hE, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("mid_rst.exec_abs", exec_count, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 80), 4'($urandom), 2'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cond_unit.md
# cond_unit

Execute-stage condition unit that consumes the `{N,Z,C,V}` flags produced by the ALU. It holds the architectural flag register, evaluates the instruction's 4-bit ARM condition field against it, and gates the register, memory, branch and PC-redirect writes of annulled instructions. It also keeps two 32-bit event counters, one for executed instructions and one for annulled instructions, for pipeline debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the event counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset; takes priority over every other input.
- `stall_e`  in  1  holds the execute stage; blocks all state updates.
- `valid_e`  in  1  execute stage holds a real instruction (0 = bubble).
- `cond_e`  in  4  condition field, instr[31:28].
- `flag_write_e`  in  2  bit 1 = write N,Z; bit 0 = write C,V.
- `alu_flags`  in  4  `{N,Z,C,V}` from the ALU, same cycle.
- `pc_src_e`, `reg_write_e`, `mem_write_e`, `branch_e`  in  1 each  ungated control from decode.
- `flags`  out  4  registered `{N,Z,C,V}`.
- `cond_ex_e`  out  1  condition passed and `valid_e` is 1.
- `pc_src_g`, `reg_write_g`, `mem_write_g`  out  1 each  input ANDed with `cond_ex_e`.
- `branch_taken_e`  out  1  `branch_e & cond_ex_e`.
- `exec_count`, `annul_count`  out  CNT_W  event counters.

## Operation
- Condition pass is evaluated on the registered `flags`, never on `alu_flags`:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C & !Z. 1001 LS: !C | Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V). 1101 LE: Z | (N!=V).
  - 1110 AL: 1. 1111: 0; the unconditional space is unsupported and always annulled.
- `cond_ex_e = pass & valid_e`. All gated outputs are purely combinational from the current inputs and `flags`.
- Flag register update happens only when `!reset & !stall_e & cond_ex_e`:
  - `flag_write_e[1]` loads `flags[3:2]` from `alu_flags[3:2]`.
  - `flag_write_e[0]` loads `flags[1:0]` from `alu_flags[1:0]`.
  - Unwritten halves hold their value.
- Counters update only when `!reset & !stall_e & valid_e`:
  - `exec_count` increments if `cond_ex_e` is 1.
  - Otherwise `annul_count` increments.
  - Both wrap modulo 2^CNT_W with no saturation or sticky overflow.
- A bubble (`valid_e`=0) changes no state and drives all gated outputs to 0.
- `stall_e` freezes the flag register and both counters. Gated outputs still follow their inputs combinationally, so downstream stage registers must honour the stall themselves.

## Timing
- Reset values: `flags`=4'b0000, `exec_count`=0, `annul_count`=0. Combinational outputs follow from these; for example, AL with `valid_e`=1 gives `cond_ex_e`=1 during reset.
- A `reset` asserted mid-stream clears state at the next edge regardless of `stall_e` or `valid_e`. That cycle's instruction is neither counted nor allowed to write flags.
- Latency: condition evaluation and gating take 0 cycles. A flag write becomes visible on `flags` 1 cycle after the edge.
- An instruction at cycle t that writes flags and an instruction at cycle t+1 that reads them are correct back-to-back; no bypass is needed.
- When an instruction both sets flags and is conditional, its own condition uses the old flags and the new flags appear at t+1.
- An annulled flag-setting instruction (for example CMPNE while Z=1) leaves `flags` unchanged.
- Stall released after N cycles: the held instruction is counted exactly once, on the first non-stalled edge.

## Test plan
- Reset, then present `cond_e`=0000, `valid_e`=1 -> `flags`=0000, `cond_ex_e`=0, both counters 0.
- Cycle 1: `alu_flags`=0100, `flag_write_e`=11, AL. Cycle 2: EQ branch with `branch_e`=1 -> `flags`=0100 and `branch_taken_e`=1 in cycle 2; `exec_count`=2.
- From `flags`=0000: write `alu_flags`=1011 with `flag_write_e`=10, then GE -> `flags`=1000, N!=V, GE fails. Then LT with `reg_write_e`=1 -> `reg_write_g`=1.
- NE with `flag_write_e`=11 while Z=1 and `alu_flags`=0010 -> `flags` unchanged, `mem_write_g`=0, `annul_count`+1.
- AL flag-setting instruction held 3 cycles by `stall_e`=1, then released -> `flags` and `exec_count` change only at the release edge, and `exec_count` increments by exactly 1.
- `cond_e`=1111 with `valid_e`=1, and separately a bubble with `cond_e`=1110, `valid_e`=0 -> first: `annul_count`+1, all gated outputs 0. Second: no counter change, all gated outputs 0.
